// File: rtl/rr_stream_master_pkg.sv
// Shared constants and width helpers for the multi-channel stream master.
package rr_stream_master_pkg;

  localparam int unsigned MODE_RR   = 0;
  localparam int unsigned MODE_PRIO = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Channel id width; a single channel still needs one bit for chan_id.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_stream_master_stream_fifo.sv
// Show-ahead per-channel buffer with registered count, full/empty and sticky overflow.
module stream_fifo
  import rr_stream_master_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  // A full buffer refuses writes even when it is popped in the same cycle.
  always_comb begin
    w_push      = i_wr_en && !r_full;
    w_pop       = i_rd_en && !r_empty;
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_empty    <= (w_count_nxt == CW'(0));
      r_overflow <= r_overflow || (i_wr_en && r_full);
    end
  end

  assign o_head_c   = r_mem[r_rd_ptr];
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/rr_stream_master.sv
// Multi-channel stream master: per-channel buffers, RR/priority arbiter, registered valid/ready output.
module rr_stream_master
  import rr_stream_master_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned MODE   = 0,
  localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       wr_en,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    valid,
  input  logic                    ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [CH_W-1:0]         chan_id
);

  logic [WIDTH-1:0]  w_head [NUM_CH];
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_pop;
  logic              w_load;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [WIDTH-1:0]  w_gnt_data;
  int unsigned       w_idx;

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [CH_W-1:0]   r_chan;
  logic [CH_W-1:0]   r_ptr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (wr_en[g]),
      .i_wr_data  (data_in[g*WIDTH +: WIDTH]),
      .i_rd_en    (w_pop[g]),
      .o_head_c   (w_head[g]),
      .o_empty    (w_empty[g]),
      .o_full     (full[g]),
      .o_overflow (overflow[g])
    );
  end

  // Scan from the lowest-preference candidate up so the most preferred non-empty one wins.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    w_idx      = 0;
    for (int unsigned i = NUM_CH; i >= 1; i--) begin
      if (MODE == MODE_PRIO) begin
        w_idx = i - 1;
      end else begin
        w_idx = (32'(r_ptr) + i) % NUM_CH;
      end
      if (!w_empty[CH_W'(w_idx)]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_idx  = CH_W'(w_idx);
        w_gnt_data = w_head[CH_W'(w_idx)];
      end
    end
  end

  always_comb begin
    w_load = !r_valid || ready;
    w_pop  = '0;
    if (w_load && w_gnt_vld) begin
      w_pop[w_gnt_idx] = 1'b1;
    end
  end

  // Output register; the RR pointer only advances on an edge that actually grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= CH_W'(NUM_CH - 1);
    end else if (w_load) begin
      r_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_data <= w_gnt_data;
        r_chan <= w_gnt_idx;
        r_ptr  <= w_gnt_idx;
      end
    end
  end

  assign valid    = r_valid;
  assign data_out = r_data;
  assign chan_id  = r_chan;

endmodule

// File: tb/tb_rr_stream_master.sv
// Directed bench: one round-robin and one fixed-priority instance driven by shared stimulus.
module tb_rr_stream_master;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NUM_CH = 4;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       wr_en;
  logic [NUM_CH*WIDTH-1:0] data_in;
  logic                    ready;

  logic [NUM_CH-1:0] full0, ovf0, full1, ovf1;
  logic              valid0, valid1;
  logic [WIDTH-1:0]  data0, data1;
  logic [1:0]        chan0, chan1;

  int checks   = 0;
  int failures = 0;

  rr_stream_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
    .full(full0), .overflow(ovf0), .valid(valid0), .ready(ready),
    .data_out(data0), .chan_id(chan0)
  );

  rr_stream_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .MODE(1)) u_pr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
    .full(full1), .overflow(ovf1), .valid(valid1), .ready(ready),
    .data_out(data1), .chan_id(chan1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_word(input int c, input logic [7:0] v);
    data_in[c*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset_idle();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b0 || data0 !== 8'h00 || chan0 !== 2'd0 || full0 !== 4'h0 || ovf0 !== 4'h0) begin
        failures++;
        $display("FAIL reset_idle_rr cyc=%0d valid=%b data=%h chan=%0d full=%b ovf=%b required all zero",
                 n, valid0, data0, chan0, full0, ovf0);
      end
      checks++;
      if (valid1 !== 1'b0 || data1 !== 8'h00 || chan1 !== 2'd0 || full1 !== 4'h0 || ovf1 !== 4'h0) begin
        failures++;
        $display("FAIL reset_idle_pr cyc=%0d valid=%b data=%h chan=%0d full=%b ovf=%b required all zero",
                 n, valid1, data1, chan1, full1, ovf1);
      end
    end
  endtask

  task automatic test_rr_prio();
    logic [7:0] exp_rr, exp_pr;
    logic [1:0] ch_rr, ch_pr;
    ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      wr_en = 4'hF;
      for (int c = 0; c < 4; c++) set_word(c, 8'(16 * c + n));
      @(negedge clk);
    end
    wr_en = 4'h0;
    checks++;
    if (valid0 !== 1'b1 || data0 !== 8'h00 || chan0 !== 2'd0) begin
      failures++;
      $display("FAIL preload_first_rr valid=%b data=%h chan=%0d required 1/00/0", valid0, data0, chan0);
    end
    checks++;
    if (valid1 !== 1'b1 || data1 !== 8'h00 || chan1 !== 2'd0) begin
      failures++;
      $display("FAIL preload_first_pr valid=%b data=%h chan=%0d required 1/00/0", valid1, data1, chan1);
    end
    ready = 1'b1;
    for (int n = 1; n < 12; n++) begin
      @(negedge clk);
      exp_rr = 8'(16 * (n % 4) + n / 4);
      ch_rr  = 2'(n % 4);
      exp_pr = 8'(16 * (n / 3) + n % 3);
      ch_pr  = 2'(n / 3);
      checks++;
      if (valid0 !== 1'b1 || data0 !== exp_rr || chan0 !== ch_rr) begin
        failures++;
        $display("FAIL rr_seq n=%0d valid=%b data=%h chan=%0d required 1/%h/%0d", n, valid0, data0, chan0, exp_rr, ch_rr);
      end
      checks++;
      if (valid1 !== 1'b1 || data1 !== exp_pr || chan1 !== ch_pr) begin
        failures++;
        $display("FAIL prio_seq n=%0d valid=%b data=%h chan=%0d required 1/%h/%0d", n, valid1, data1, chan1, exp_pr, ch_pr);
      end
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
      failures++;
      $display("FAIL seq_drained valid_rr=%b valid_pr=%b required 0/0", valid0, valid1);
    end
    ready = 1'b0;
  endtask

  task automatic test_latency();
    ready = 1'b1;
    wr_en = 4'b0100;
    set_word(2, 8'hA5);
    @(negedge clk);
    wr_en = 4'h0;
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
      failures++;
      $display("FAIL latency_k valid_rr=%b valid_pr=%b required 0/0", valid0, valid1);
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b1 || data0 !== 8'hA5 || chan0 !== 2'd2) begin
      failures++;
      $display("FAIL latency_k1_rr valid=%b data=%h chan=%0d required 1/a5/2", valid0, data0, chan0);
    end
    checks++;
    if (valid1 !== 1'b1 || data1 !== 8'hA5 || chan1 !== 2'd2) begin
      failures++;
      $display("FAIL latency_k1_pr valid=%b data=%h chan=%0d required 1/a5/2", valid1, data1, chan1);
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b0 || data0 !== 8'hA5 || chan0 !== 2'd2 || valid1 !== 1'b0 || data1 !== 8'hA5) begin
      failures++;
      $display("FAIL latency_k2 valid_rr=%b data_rr=%h chan_rr=%0d valid_pr=%b data_pr=%h required 0/a5/2/0/a5",
               valid0, data0, chan0, valid1, data1);
    end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_w [4][4];
    int rd0 [4];
    int rd1 [4];
    logic [7:0] held0, held1;
    logic [1:0] hch0, hch1;
    for (int c = 0; c < 4; c++) begin
      rd0[c] = 0;
      rd1[c] = 0;
      for (int k = 0; k < 4; k++) exp_w[c][k] = 8'hxx;
    end
    exp_w[1][0] = 8'h55;
    exp_w[3][0] = 8'h71;
    exp_w[3][1] = 8'h72;
    ready = 1'b0;
    wr_en = 4'b1010;
    set_word(1, 8'h55);
    set_word(3, 8'h71);
    @(negedge clk);
    wr_en = 4'b1000;
    set_word(3, 8'h72);
    @(negedge clk);
    wr_en = 4'h0;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if (valid0 !== 1'b1 || rd0[chan0] > 3 || data0 !== exp_w[chan0][rd0[chan0]]) begin
        failures++;
        $display("FAIL bp_sb_rr n=%0d valid=%b data=%h chan=%0d required scoreboard word", n, valid0, data0, chan0);
      end
      if (rd0[chan0] < 4) rd0[chan0]++;
      checks++;
      if (valid1 !== 1'b1 || rd1[chan1] > 3 || data1 !== exp_w[chan1][rd1[chan1]]) begin
        failures++;
        $display("FAIL bp_sb_pr n=%0d valid=%b data=%h chan=%0d required scoreboard word", n, valid1, data1, chan1);
      end
      if (rd1[chan1] < 4) rd1[chan1]++;
      if (n == 0) begin
        held0 = data0; hch0 = chan0;
        held1 = data1; hch1 = chan1;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++;
          if (valid0 !== 1'b1 || data0 !== held0 || chan0 !== hch0 || valid1 !== 1'b1 || data1 !== held1 || chan1 !== hch1) begin
            failures++;
            $display("FAIL bp_hold s=%0d rr=%b/%h/%0d pr=%b/%h/%0d required 1/%h/%0d and 1/%h/%0d",
                     s, valid0, data0, chan0, valid1, data1, chan1, held0, hch0, held1, hch1);
          end
        end
        ready = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0 || rd0[1] != 1 || rd0[3] != 2 || rd1[1] != 1 || rd1[3] != 2) begin
      failures++;
      $display("FAIL bp_complete valid_rr=%b valid_pr=%b rr_ch1=%0d rr_ch3=%0d pr_ch1=%0d pr_ch3=%0d required 0/0/1/2/1/2",
               valid0, valid1, rd0[1], rd0[3], rd1[1], rd1[3]);
    end
    ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [3:0] exp_full, exp_ovf;
    ready = 1'b0;
    wr_en = 4'b0001;
    set_word(0, 8'hEE);
    @(negedge clk);
    wr_en = 4'h0;
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b1 || data0 !== 8'hEE || valid1 !== 1'b1 || data1 !== 8'hEE) begin
      failures++;
      $display("FAIL ovf_parked rr=%b/%h pr=%b/%h required 1/ee", valid0, data0, valid1, data1);
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 4'b0010;
      set_word(1, 8'(i));
      @(negedge clk);
      exp_full = (i + 1 >= DEPTH) ? 4'b0010 : 4'b0000;
      exp_ovf  = (i + 1 > DEPTH) ? 4'b0010 : 4'b0000;
      checks++;
      if (full0 !== exp_full || ovf0 !== exp_ovf || full1 !== exp_full || ovf1 !== exp_ovf) begin
        failures++;
        $display("FAIL ovf_fill w=%0d full_rr=%b ovf_rr=%b full_pr=%b ovf_pr=%b required full=%b ovf=%b",
                 i + 1, full0, ovf0, full1, ovf1, exp_full, exp_ovf);
      end
    end
    wr_en = 4'h0;
    ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b1 || data0 !== 8'(j) || chan0 !== 2'd1 || valid1 !== 1'b1 || data1 !== 8'(j) || chan1 !== 2'd1) begin
        failures++;
        $display("FAIL ovf_drain j=%0d rr=%b/%h/%0d pr=%b/%h/%0d required 1/%h/1", j, valid0, data0, chan0,
                 valid1, data1, chan1, 8'(j));
      end
    end
    @(negedge clk);
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0 || full0 !== 4'h0 || ovf0 !== 4'b0010 || ovf1 !== 4'b0010) begin
      failures++;
      $display("FAIL ovf_after_drain valid_rr=%b valid_pr=%b full_rr=%b ovf_rr=%b ovf_pr=%b required 0/0/0000/0010/0010",
               valid0, valid1, full0, ovf0, ovf1);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_en = 4'b0100;
    set_word(2, 8'h3C);
    @(negedge clk);
    wr_en = 4'b0100;
    set_word(2, 8'h3D);
    @(negedge clk);
    wr_en = 4'h0;
    checks++;
    if (valid0 !== 1'b1 || data0 !== 8'h3C) begin
      failures++;
      $display("FAIL rst_mid_pre valid=%b data=%h required 1/3c", valid0, data0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid0 !== 1'b0 || valid1 !== 1'b0 || ovf0 !== 4'h0 || ovf1 !== 4'h0 || data0 !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_async valid_rr=%b valid_pr=%b ovf_rr=%b ovf_pr=%b data_rr=%h required 0/0/0000/0000/00",
               valid0, valid1, ovf0, ovf1, data0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (valid0 !== 1'b0 || valid1 !== 1'b0 || full0 !== 4'h0 || chan0 !== 2'd0) begin
        failures++;
        $display("FAIL rst_mid_discard n=%0d valid_rr=%b valid_pr=%b full=%b chan=%0d required 0/0/0000/0",
                 n, valid0, valid1, full0, chan0);
      end
    end
    ready = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = '0;
    data_in = '0;
    ready   = 1'b0;
    #23 rst_n = 1'b1;
    test_reset_idle();
    test_rr_prio();
    test_latency();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_stream_master.md
Name: rr_stream_master

Overview:
- Multi-channel successor to the single-channel FIFO-backed stream master.
- Each of NUM_CH producers writes into its own show-ahead buffer.
- An arbiter (round-robin or fixed-priority, set by parameter) selects one non-empty channel per transfer and drives a registered valid/ready output stream tagged with the source channel id.
- Sits between local producers and a downstream valid/ready consumer.

Parameters:
- WIDTH, 8, data bits per word.
- DEPTH, 16, words per channel buffer; power of 2, ≥2.
- NUM_CH, 4, number of input channels; ≥1.
- MODE, 0, arbitration: 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  NUM_CH  per-channel write strobe.
- data_in  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- full  out  NUM_CH  per-channel buffer full (registered count == DEPTH).
- overflow  out  NUM_CH  sticky: a write was attempted while full.
- valid  out  1  output word present.
- ready  in  1  consumer accepts the word.
- data_out  out  WIDTH  output word.
- chan_id  out  CH_W  source channel of data_out; CH_W = max(1, clog2(NUM_CH)).

Behaviour:
- Reset (async assert, sync release): all buffers empty, full=0, overflow=0, valid=0, data_out=0, chan_id=0, RR pointer=NUM_CH-1, so channel 0 is searched first.
- Write: a word is accepted when wr_en[c] && !full[c]. When wr_en[c] && full[c], the word is dropped, overflow[c] sets, and it stays set until reset. A full buffer never accepts a write, even if a read of it happens in the same cycle.
- Buffer: show-ahead. The head word is visible combinationally to the arbiter. Pointers wrap modulo DEPTH. A count register of width clog2(DEPTH)+1 drives full and empty.
- Transfer occurs on any edge where valid && ready.
- Load condition: load = !valid || ready.
  - On a load edge with at least one non-empty channel: the granted channel's head moves into data_out/chan_id, its buffer pops, and valid=1.
  - On a load edge with all channels empty: valid goes to 0; data_out and chan_id hold their old values.
- Hold rule: while valid && !ready, data_out and chan_id are stable and no buffer pops.
- Throughput: back-to-back words, one per cycle, while ready=1 and data is available. No bubble is inserted between channels.
- Latency: a word written at edge k into an idle block (all empty, valid=0) appears with valid=1 after edge k+1.
- Simultaneous push and pop on the same channel in the same edge: both take effect and count is unchanged.
- MODE 0 (round-robin):
  - Search order is ptr+1, ptr+2, … modulo NUM_CH.
  - The grant is the first non-empty channel.
  - ptr updates to the granted channel only on a load edge that actually grants.
- MODE 1 (fixed priority): the lowest-index non-empty channel wins; no pointer is kept.
- NUM_CH=1: the arbiter degenerates to that channel and chan_id is held at 0.
- Reset mid-stream: all buffered words are discarded, valid drops immediately (asynchronously), and overflow flags clear.

Decomposition:
- Shared package contents:
  - clog2 function.
  - MODE_RR=0 and MODE_PRIO=1 constants.
  - CH_W derivation.
- Sub-module stream_fifo:
  - Parameters WIDTH and DEPTH.
  - Show-ahead, with registered count/full/empty.
  - Async active-low reset.
  - NUM_CH instances generated.
- Arbiter and output register live in the top level.

Test Plan:
- Reset then idle, all wr_en=0 -> valid=0, data_out=0, chan_id=0, full=0, overflow=0 for 20 cycles.
- Latency, ready=1: ch2 writes 0xA5 at edge k -> valid=1, data_out=0xA5, chan_id=2 after edge k+1; valid=0 after edge k+2.
- Round-robin, MODE=0, ready=1: each channel preloaded with 3 words (ch c word n = 0x10*c+n) -> output sequence 0x00,0x10,0x20,0x30,0x01,0x11,…,0x32 with no gaps, chan_id cycling 0,1,2,3.
- Same preload with MODE=1 -> all ch0 words, then ch1, then ch2, then ch3 (0x00,0x01,0x02,0x10,…).
- Backpressure: ready=0 for 5 cycles while valid=1 -> data_out/chan_id unchanged and no buffer pops. ready=1 -> next word on the following edge with no loss or duplication (scoreboard per channel).
- Overflow: write DEPTH+2 words to ch1 with ready=0 -> full[1]=1 after DEPTH accepted writes, overflow[1]=1 and stays set. Drain -> exactly DEPTH words output (0..DEPTH-1) and overflow[1] remains 1 until rst_n pulse.
